// File: rtl/fir_pkg.sv
// Shared width helpers and reset-time coefficient values for the FIR filter.
package fir_pkg;

  function automatic int prodWidth(input int inW, input int coefW);
    return inW + coefW;
  endfunction

  function automatic int outWidth(input int taps, input int inW, input int coefW);
    return inW + coefW + $clog2(taps);
  endfunction

  function automatic int addrWidth(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  // Coefficient loaded into tap k whenever the filter is reset.
  function automatic int defaultCoef(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fir_tap.sv
// One FIR tap: a delay-line register followed by a registered signed multiply.
module fir_tap
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter int COEF_WIDTH  = 8,
  localparam int PROD_WIDTH = prodWidth(INPUT_WIDTH, COEF_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_i,
  input  logic signed [INPUT_WIDTH-1:0] sample_i,
  input  logic signed [COEF_WIDTH-1:0]  coef_i,
  output logic signed [INPUT_WIDTH-1:0] sample_o,
  output logic signed [PROD_WIDTH-1:0]  product_o
);

  logic signed [INPUT_WIDTH-1:0] sample_q;
  logic signed [PROD_WIDTH-1:0]  product_d;
  logic signed [PROD_WIDTH-1:0]  product_q;

  // Both operands are widened first so the multiply runs at full product width.
  always_comb begin
    product_d = PROD_WIDTH'(sample_q) * PROD_WIDTH'(coef_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q  <= '0;
      product_q <= '0;
    end else begin
      if (shift_i) begin
        sample_q <= sample_i;
      end
      product_q <= product_d;
    end
  end

  assign sample_o  = sample_q;
  assign product_o = product_q;

endmodule

// File: rtl/fir_filter.sv
// Direct-form FIR filter: tap chain, coefficient bank, adder stage and valid pipeline.
module fir_filter
  import fir_pkg::*;
#(
  parameter int NUM_OF_TAPS = 3,
  parameter int INPUT_WIDTH = 8,
  parameter int COEF_WIDTH  = 8,
  localparam int OUTPUT_WIDTH = outWidth(NUM_OF_TAPS, INPUT_WIDTH, COEF_WIDTH),
  localparam int ADDR_WIDTH   = addrWidth(NUM_OF_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [INPUT_WIDTH-1:0] input_data,
  input  logic                          input_data_flag,
  input  logic                          coef_wr_en,
  input  logic [ADDR_WIDTH-1:0]         coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_data,
  output logic signed [OUTPUT_WIDTH-1:0] output_data,
  output logic                          output_data_flag
);

  localparam int PROD_WIDTH = prodWidth(INPUT_WIDTH, COEF_WIDTH);

  logic signed [COEF_WIDTH-1:0]   coef_q      [NUM_OF_TAPS];
  logic signed [INPUT_WIDTH-1:0]  sampleChain [NUM_OF_TAPS+1];
  logic signed [PROD_WIDTH-1:0]   product_w   [NUM_OF_TAPS];
  logic signed [INPUT_WIDTH-1:0]  tail_unused;
  logic signed [OUTPUT_WIDTH-1:0] sum_d;
  logic signed [OUTPUT_WIDTH-1:0] out_q;
  logic [1:0]                     valid_q;
  logic                           outFlag_q;

  assign sampleChain[0] = input_data;
  // The oldest sample simply falls off the end of the delay line.
  assign tail_unused = sampleChain[NUM_OF_TAPS];

  for (genvar k = 0; k < NUM_OF_TAPS; k++) begin : gTap
    fir_tap #(
      .INPUT_WIDTH(INPUT_WIDTH),
      .COEF_WIDTH (COEF_WIDTH)
    ) uTap (
      .clk      (clk),
      .rst      (rst),
      .shift_i  (input_data_flag),
      .sample_i (sampleChain[k]),
      .coef_i   (coef_q[k]),
      .sample_o (sampleChain[k+1]),
      .product_o(product_w[k])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NUM_OF_TAPS; k++) begin
      sum_d = sum_d + OUTPUT_WIDTH'(product_w[k]);
    end
  end

  // valid_q[0] marks a fresh capture, valid_q[1] marks products ready to sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        coef_q[k] <= COEF_WIDTH'(defaultCoef(k));
      end
      valid_q   <= '0;
      out_q     <= '0;
      outFlag_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OF_TAPS; k++) begin
        if (coef_wr_en && (coef_addr == ADDR_WIDTH'(k))) begin
          coef_q[k] <= coef_data;
        end
      end
      valid_q   <= {valid_q[0], input_data_flag};
      outFlag_q <= valid_q[1];
      if (valid_q[1]) begin
        out_q <= sum_d;
      end
    end
  end

  assign output_data      = out_q;
  assign output_data_flag = outFlag_q;

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: directed samples push expected results, a monitor checks them.
module tb_fir_filter;

  typedef struct {
    longint value;
    int     cycle;
  } expect_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         input_data;
  logic               input_data_flag;
  logic               coef_wr_en;
  logic [1:0]         coef_addr;
  logic [7:0]         coef_data;
  logic signed [17:0] output_data;
  logic               output_data_flag;

  expect_t sb[$];
  expect_t popped;
  int      cycleCount = 0;
  int      pulseCount = 0;
  int      checkCount = 0;
  int      passCount  = 0;

  fir_filter dut (
    .clk             (clk),
    .rst             (rst),
    .input_data      (input_data),
    .input_data_flag (input_data_flag),
    .coef_wr_en      (coef_wr_en),
    .coef_addr       (coef_addr),
    .coef_data       (coef_data),
    .output_data     (output_data),
    .output_data_flag(output_data_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One cycle of stimulus; a flagged sample's result is due two edges after its capture edge.
  task automatic applyStimulus(input bit flag, input logic [7:0] sample, input bit wr,
                               input logic [1:0] addr, input logic [7:0] cdata,
                               input bit hasExp, input longint expVal);
    expect_t e;
    @(negedge clk);
    input_data_flag = flag;
    input_data      = sample;
    coef_wr_en      = wr;
    coef_addr       = addr;
    coef_data       = cdata;
    if (hasExp) begin
      e.value = expVal;
      e.cycle = cycleCount + 3;
      sb.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst             = 1'b1;
    input_data_flag = 1'b0;
    coef_wr_en      = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (output_data_flag) begin
      pulseCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected pulse", 1, 0);
      end else begin
        popped = sb.pop_front();
        checkOutput("result", output_data, popped.value);
        checkOutput("latency", cycleCount, popped.cycle);
      end
    end
  end

  initial begin
    int waited;
    int pulsesBefore;
    rst             = 1'b1;
    input_data      = 8'h00;
    input_data_flag = 1'b0;
    coef_wr_en      = 1'b0;
    coef_addr       = 2'd0;
    coef_data       = 8'h00;

    @(negedge clk);
    checkOutput("reset output_data", output_data, 0);
    checkOutput("reset flag", output_data_flag, 0);
    @(negedge clk);
    rst = 1'b0;

    // Default coefficients 1,2,3 with samples 90 ns apart.
    applyStimulus(1'b1, 8'hDE, 1'b0, 2'd0, 8'h00, 1'b1, -34);
    idleCycles(8);
    applyStimulus(1'b1, 8'hAD, 1'b0, 2'd0, 8'h00, 1'b1, -151);
    idleCycles(8);
    applyStimulus(1'b1, 8'hBE, 1'b0, 2'd0, 8'h00, 1'b1, -334);
    idleCycles(8);
    checkOutput("hold output_data", output_data, -334);
    checkOutput("hold flag low", output_data_flag, 0);

    // Impulse response with the flag held high.
    resetDut();
    applyStimulus(1'b1, 8'h01, 1'b0, 2'd0, 8'h00, 1'b1, 1);
    applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2);
    applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 3);
    applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 0);
    idleCycles(4);

    // Most negative coefficients and samples: full precision, no wrap.
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 8'h80, 1'b0, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd1, 8'h80, 1'b0, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd2, 8'h80, 1'b0, 0);
    applyStimulus(1'b1, 8'h80, 1'b0, 2'd0, 8'h00, 1'b1, 16384);
    applyStimulus(1'b1, 8'h80, 1'b0, 2'd0, 8'h00, 1'b1, 32768);
    applyStimulus(1'b1, 8'h80, 1'b0, 2'd0, 8'h00, 1'b1, 49152);
    idleCycles(4);

    // Out-of-range coefficient address must leave 1,2,3 intact.
    resetDut();
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd3, 8'h7F, 1'b0, 0);
    applyStimulus(1'b1, 8'hDE, 1'b0, 2'd0, 8'h00, 1'b1, -34);
    idleCycles(2);
    applyStimulus(1'b1, 8'hAD, 1'b0, 2'd0, 8'h00, 1'b1, -151);
    idleCycles(2);
    applyStimulus(1'b1, 8'hBE, 1'b0, 2'd0, 8'h00, 1'b1, -334);
    idleCycles(4);

    // Reset one edge after a capture discards the sample and restores coefficients.
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 8'h05, 1'b0, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd1, 8'h05, 1'b0, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd2, 8'h05, 1'b0, 0);
    pulsesBefore = pulseCount;
    applyStimulus(1'b1, 8'h05, 1'b0, 2'd0, 8'h00, 1'b0, 0);
    resetDut();
    idleCycles(5);
    checkOutput("no pulse for flushed sample", pulseCount, pulsesBefore);
    checkOutput("output cleared by reset", output_data, 0);
    applyStimulus(1'b1, 8'h01, 1'b0, 2'd0, 8'h00, 1'b1, 1);
    applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2);
    applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 3);
    idleCycles(4);

    // Write on the capture edge is seen; write on the product edge is not.
    resetDut();
    applyStimulus(1'b1, 8'h02, 1'b1, 2'd0, 8'd10, 1'b1, 20);
    idleCycles(3);
    applyStimulus(1'b1, 8'h03, 1'b0, 2'd0, 8'h00, 1'b1, 34);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 8'd100, 1'b0, 0);
    idleCycles(4);

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("scoreboard drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
